traffic_lamp_monitor: RTL and testbench

Cycle-accurate checker for the 6-bit lamp vector driven by the intersection light controller.
- Registers the lamp outputs, decodes them into a phase and measures how long each phase is held.
- Checks every phase change against the legal A/B sequence and the dwell limits.
- Latches the first violation as a sticky fault code.
- Sits beside the controller on the same clock and feeds the board fault LED and status logic.

---
 rtl/traffic_lamp_monitor_if.sv | 24 ++
 rtl/traffic_lamp_monitor.sv | 177 +++++++++++++++++
 tb/tb_traffic_lamp_monitor.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_lamp_monitor_if.sv
// Signal bundle between the intersection light controller side and traffic_lamp_monitor.
// master drives the lamp vector and fault clear; slave is the monitor itself.
interface traffic_lamp_monitor_if;
    logic [5:0]  lamps;
    logic        clear_fault;
    logic [2:0]  phase;
    logic        phase_valid;
    logic [7:0]  dwell;
    logic        locked;
    logic        fault;
    logic [2:0]  fault_code;
    logic        cycle_done;
    logic [15:0] cycle_count;

    modport master (
        output lamps, clear_fault,
        input  phase, phase_valid, dwell, locked, fault, fault_code, cycle_done, cycle_count
    );

    modport slave (
        input  lamps, clear_fault,
        output phase, phase_valid, dwell, locked, fault, fault_code, cycle_done, cycle_count
    );
endinterface

// File: rtl/traffic_lamp_monitor.sv
// Cycle-accurate checker for the 6-bit intersection lamp vector: phase decode, dwell, sticky fault.
// Optional macro TRAFFIC_LAMP_MON_MIN_DWELL_EN compiles in the minimum-dwell (code 3) check.
module traffic_lamp_monitor #(
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 3,
    parameter int MIN_ALLRED = 3,
    parameter int MAX_DWELL  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    traffic_lamp_monitor_if.slave bus
);

    localparam logic [5:0] PAT_P0 = 6'b100001;
    localparam logic [5:0] PAT_P1 = 6'b010001;
    localparam logic [5:0] PAT_P2 = 6'b001001;
    localparam logic [5:0] PAT_P3 = 6'b001100;
    localparam logic [5:0] PAT_P4 = 6'b001010;

    localparam logic [2:0] PH_A_GREEN  = 3'd0;
    localparam logic [2:0] PH_A_YELLOW = 3'd1;
    localparam logic [2:0] PH_ALL_RED  = 3'd2;
    localparam logic [2:0] PH_B_GREEN  = 3'd3;
    localparam logic [2:0] PH_B_YELLOW = 3'd4;
    localparam logic [2:0] PH_NONE     = 3'd7;

    localparam logic [1:0] ST_SYNC   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    localparam logic [2:0] CODE_NONE       = 3'd0;
    localparam logic [2:0] CODE_PATTERN    = 3'd1;
    localparam logic [2:0] CODE_TRANSITION = 3'd2;
    localparam logic [2:0] CODE_SHORT      = 3'd3;
    localparam logic [2:0] CODE_TIMEOUT    = 3'd4;

    localparam logic [7:0] MAX_LIM = 8'(MAX_DWELL);

    logic [5:0]  lamps_q;
    logic [1:0]  state;
    logic        served_a;
    logic [7:0]  dwell_q;
    logic [2:0]  fault_code_q;
    logic        cycle_done_q;
    logic [15:0] cycle_count_q;

    logic [2:0] in_phase;
    logic [2:0] held_phase;
    logic       in_legal;
    logic       change;
    logic       step_ok;
    logic       too_short;
    logic [2:0] viol_code;

    function automatic logic [2:0] decode(input logic [5:0] v);
        case (v)
            PAT_P0:  decode = PH_A_GREEN;
            PAT_P1:  decode = PH_A_YELLOW;
            PAT_P2:  decode = PH_ALL_RED;
            PAT_P3:  decode = PH_B_GREEN;
            PAT_P4:  decode = PH_B_YELLOW;
            default: decode = PH_NONE;
        endcase
    endfunction

    assign in_phase   = decode(bus.lamps);
    assign held_phase = decode(lamps_q);
    assign in_legal   = (in_phase != PH_NONE);
    assign change     = (bus.lamps != lamps_q);

    // The all-red exit direction depends on which road was served last.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        step_ok = 1'b0;
        case (held_phase)
            PH_A_GREEN:  step_ok = (in_phase == PH_A_YELLOW);
            PH_A_YELLOW: step_ok = (in_phase == PH_ALL_RED);
            PH_ALL_RED:  step_ok = served_a ? (in_phase == PH_B_GREEN) : (in_phase == PH_A_GREEN);
            PH_B_GREEN:  step_ok = (in_phase == PH_B_YELLOW);
            PH_B_YELLOW: step_ok = (in_phase == PH_ALL_RED);
            default:     step_ok = 1'b0;
        endcase
    end

`ifdef TRAFFIC_LAMP_MON_MIN_DWELL_EN
    logic [7:0] min_lim;

    always_comb begin
        case (held_phase)
            PH_A_GREEN, PH_B_GREEN:   min_lim = 8'(MIN_GREEN);
            PH_A_YELLOW, PH_B_YELLOW: min_lim = 8'(MIN_YELLOW);
            default:                  min_lim = 8'(MIN_ALLRED);
        endcase
    end

    assign too_short = change && (dwell_q < min_lim);
`else
    assign too_short = 1'b0;
`endif

    // Priority order: pattern > transition > short dwell > timeout.
    always_comb begin
        viol_code = CODE_NONE;
        if (!in_legal)
            viol_code = CODE_PATTERN;
        else if (change && !step_ok)
            viol_code = CODE_TRANSITION;
        else if (too_short)
            viol_code = CODE_SHORT;
        else if (!change && (dwell_q == MAX_LIM))
            viol_code = CODE_TIMEOUT;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
        if (!rst_n) begin
            lamps_q       <= 6'b000000;
            state         <= ST_SYNC;
            served_a      <= 1'b0;
            dwell_q       <= 8'd0;
            fault_code_q  <= CODE_NONE;
            cycle_done_q  <= 1'b0;
            cycle_count_q <= 16'd0;
        end else begin
            lamps_q      <= bus.lamps;
            cycle_done_q <= 1'b0;

            if (change)
                dwell_q <= 8'd1;
            else if (dwell_q != 8'hFF)
                dwell_q <= dwell_q + 8'd1;

            if (change && (held_phase == PH_A_YELLOW) && (in_phase == PH_ALL_RED))
                served_a <= 1'b1;
            if (change && (held_phase == PH_B_YELLOW) && (in_phase == PH_ALL_RED))
                served_a <= 1'b0;

            if (bus.clear_fault) begin
                state        <= ST_SYNC;
                fault_code_q <= CODE_NONE;
            end else begin
                case (state)
                    ST_SYNC: begin
                        if (!in_legal) begin
                            state        <= ST_FAULT;
                            fault_code_q <= CODE_PATTERN;
                        end else if ((bus.lamps == PAT_P0) && (lamps_q != PAT_P0)) begin
                            state    <= ST_LOCKED;
                            served_a <= 1'b0;
                        end
                    end
                    ST_LOCKED: begin
                        if (viol_code != CODE_NONE) begin
                            state        <= ST_FAULT;
                            fault_code_q <= viol_code;
                        end else if (change && (held_phase == PH_ALL_RED) && (in_phase == PH_A_GREEN)) begin
                            cycle_done_q  <= 1'b1;
                            cycle_count_q <= cycle_count_q + 16'd1;
                        end
                    end
                    ST_FAULT: ;
                    default:  state <= ST_SYNC;
                endcase
            end
        end
    end

    assign bus.phase       = held_phase;
    assign bus.phase_valid = (held_phase != PH_NONE);
    assign bus.dwell       = dwell_q;
    assign bus.locked      = (state == ST_LOCKED);
    assign bus.fault       = (state == ST_FAULT);
    assign bus.fault_code  = fault_code_q;
    assign bus.cycle_done  = cycle_done_q;
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Self-checking bench for traffic_lamp_monitor: directed scenarios plus a randomized lamp walk
// compared every cycle against a run-length reference model.
module tb_traffic_lamp_monitor;

    localparam int MAX_DWELL = 64;

    localparam logic [5:0] P0 = 6'b100001;
    localparam logic [5:0] P1 = 6'b010001;
    localparam logic [5:0] P2 = 6'b001001;
    localparam logic [5:0] P3 = 6'b001100;
    localparam logic [5:0] P4 = 6'b001010;

    logic clk;
    logic rst_n;

    traffic_lamp_monitor_if bus ();

    traffic_lamp_monitor #(
        .MIN_GREEN  (4),
        .MIN_YELLOW (3),
        .MIN_ALLRED (3),
        .MAX_DWELL  (MAX_DWELL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;
    int done_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    endtask

    // Reference model: phases as indices into a pattern table, dwell as an unbounded run length.
    typedef enum int {M_SYNC, M_LOCKED, M_FAULT} mode_t;

    logic [5:0] pats [5];
    int         mins [5];
    logic [5:0] m_prev;
    int         m_run;
    mode_t      m_mode;
    int         m_code;
    bit         m_served_a;
    int         m_cycles;
    bit         m_done;

    function automatic int pat_index(input logic [5:0] v);
        pat_index = -1;
        for (int i = 0; i < 5; i++)
            if (pats[i] == v) pat_index = i;
    endfunction

    function automatic bit legal_move(input int f, input int t, input bit served_a);
        legal_move = (f == 0 && t == 1) || (f == 1 && t == 2) || (f == 3 && t == 4) ||
                     (f == 4 && t == 2) || (f == 2 && t == 3 && served_a) ||
                     (f == 2 && t == 0 && !served_a);
    endfunction

    task automatic model_edge(input bit rstn, input logic [5:0] l, input bit clr);
        int f;
        int t;
        int c;
        bit chg;
        if (!rstn) begin
            m_prev = 6'b0; m_run = 0; m_mode = M_SYNC; m_code = 0;
            m_served_a = 1'b0; m_cycles = 0; m_done = 1'b0;
            return;
        end
        f = pat_index(m_prev);
        t = pat_index(l);
        chg = (l != m_prev);
        m_done = 1'b0;
        if (chg && f == 1 && t == 2) m_served_a = 1'b1;
        if (chg && f == 4 && t == 2) m_served_a = 1'b0;
        if (clr) begin
            m_mode = M_SYNC;
            m_code = 0;
        end else if (m_mode == M_SYNC) begin
            if (t < 0) begin
                m_mode = M_FAULT; m_code = 1;
            end else if (t == 0 && f != 0) begin
                m_mode = M_LOCKED; m_served_a = 1'b0;
            end
        end else if (m_mode == M_LOCKED) begin
            c = 0;
            if (t < 0) c = 1;
            else if (chg && !legal_move(f, t, m_served_a)) c = 2;
`ifdef TRAFFIC_LAMP_MON_MIN_DWELL_EN
            else if (chg && m_run < mins[f]) c = 3;
`endif
            else if (!chg && m_run + 1 > MAX_DWELL) c = 4;
            if (c != 0) begin
                m_mode = M_FAULT; m_code = c;
            end else if (chg && f == 2 && t == 0) begin
                m_done = 1'b1;
                m_cycles = (m_cycles + 1) % 65536;
            end
        end
        m_run = chg ? 1 : m_run + 1;
        m_prev = l;
    endtask

    task automatic compare_all();
        int idx;
        idx = pat_index(m_prev);
        check("phase",       32'(bus.phase),       (idx < 0) ? 32'd7 : 32'(idx));
        check("phase_valid", 32'(bus.phase_valid), (idx < 0) ? 32'd0 : 32'd1);
        check("dwell",       32'(bus.dwell),       (m_run > 255) ? 32'd255 : 32'(m_run));
        check("locked",      32'(bus.locked),      (m_mode == M_LOCKED) ? 32'd1 : 32'd0);
        check("fault",       32'(bus.fault),       (m_mode == M_FAULT) ? 32'd1 : 32'd0);
        check("fault_code",  32'(bus.fault_code),  32'(m_code));
        check("cycle_done",  32'(bus.cycle_done),  32'(m_done));
        check("cycle_count", 32'(bus.cycle_count), 32'(m_cycles));
    endtask

    task automatic step(input logic [5:0] l, input bit clr);
        bus.lamps       = l;
        bus.clear_fault = clr;
        @(posedge clk);
        model_edge(rst_n, l, clr);
        #1;
        if (bus.cycle_done === 1'b1) done_pulses++;
        compare_all();
    endtask

    task automatic hold(input logic [5:0] l, input int n);
        for (int i = 0; i < n; i++) step(l, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(P2, 1'b0);
        step(P2, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic lock_and_reach_p2();
        do_reset();
        hold(P0, 5);
        hold(P1, 4);
        hold(P2, 4);
    endtask

    logic [5:0] seq [6];
    int         pos;
    int         r;
    logic [5:0] rnd;

    initial begin
        n_checks = 0; n_pass = 0; done_pulses = 0;
        pats = '{P0, P1, P2, P3, P4};
        mins = '{4, 3, 3, 4, 3};
        seq  = '{P0, P1, P2, P3, P4, P2};
        bus.lamps = P2;
        bus.clear_fault = 1'b0;
        rst_n = 1'b0;

        // Reset values.
        do_reset();
        check("rst_phase", 32'(bus.phase), 32'd7);
        check("rst_dwell", 32'(bus.dwell), 32'd0);
        check("rst_count", 32'(bus.cycle_count), 32'd0);

        // Nominal: two full A/B cycles.
        done_pulses = 0;
        hold(P0, 6);
        check("nom_locked", 32'(bus.locked), 32'd1);
        for (int k = 0; k < 2; k++) begin
            hold(P1, 4); hold(P2, 4); hold(P3, 11); hold(P4, 4); hold(P2, 6);
            hold(P0, 6);
        end
        check("nom_fault", 32'(bus.fault), 32'd0);
        check("nom_pulses", 32'(done_pulses), 32'd2);
        check("nom_count", 32'(bus.cycle_count), 32'd2);

        // Illegal pattern, then a long hold that must not change the code.
        do_reset();
        hold(P0, 5);
        step(6'b100100, 1'b0);
        check("illegal_fault", 32'(bus.fault), 32'd1);
        check("illegal_code", 32'(bus.fault_code), 32'd1);
        hold(P3, 70);
        check("illegal_sticky", 32'(bus.fault_code), 32'd1);

        // Skipped yellow.
        do_reset();
        hold(P0, 5);
        step(P2, 1'b0);
        check("skip_code", 32'(bus.fault_code), 32'd2);

        // All-red after A served must not return to A green.
        lock_and_reach_p2();
        step(P0, 1'b0);
        check("wrong_dir_code", 32'(bus.fault_code), 32'd2);

        // Short yellow.
        do_reset();
        hold(P0, 5);
        hold(P1, 2);
        step(P2, 1'b0);
`ifdef TRAFFIC_LAMP_MON_MIN_DWELL_EN
        check("short_code", 32'(bus.fault_code), 32'd3);
`else
        check("short_code", 32'(bus.fault_code), 32'd0);
`endif

        // Timeout on a long B green.
        lock_and_reach_p2();
        hold(P3, 64);
        check("pre_timeout_fault", 32'(bus.fault), 32'd0);
        check("pre_timeout_dwell", 32'(bus.dwell), 32'd64);
        step(P3, 1'b0);
        check("timeout_code", 32'(bus.fault_code), 32'd4);
        check("timeout_dwell", 32'(bus.dwell), 32'd65);

        // Clear beats a simultaneous violation, then re-lock on P0 entry.
        step(6'b000000, 1'b1);
        check("clear_fault", 32'(bus.fault), 32'd0);
        check("clear_locked", 32'(bus.locked), 32'd0);
        step(P0, 1'b0);
        check("relock", 32'(bus.locked), 32'd1);

        // Randomized walk: mostly legal sequence with injected faults, clears and resets.
        do_reset();
        pos = 0;
        for (int seg = 0; seg < 500; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset();
            end else if (r < 8 || (m_mode == M_FAULT && r < 35)) begin
                step(seq[pos], 1'b1);
            end else if (r < 11) begin
                rnd = 6'($urandom);
                step(rnd, 1'b0);
            end else if (r < 14) begin
                pos = $urandom_range(0, 5);
                hold(seq[pos], $urandom_range(1, 6));
            end else begin
                pos = (pos + 1) % 6;
                if ($urandom_range(0, 99) < 4)
                    hold(seq[pos], $urandom_range(60, 70));
                else
                    hold(seq[pos], $urandom_range(2, 8));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
